// File: rtl/pgm_ctr_fetch.sv
// pgm_ctr_fetch: program-counter stage feeding the instruction-memory address.
// Runs one program per start/done handshake. Each cycle the PC holds, increments,
// or loads an absolute target from the branch LUT. It also counts completed
// instructions (saturating) and keeps a sticky flag when the PC wraps.
module pgm_ctr_fetch #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             stall,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             wrap_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_running;
    logic             r_done;
    logic             r_wrap;

    logic [CNT_W-1:0] w_cnt_next;
    logic [PC_W-1:0]  w_pc_inc;
    logic             w_pc_at_max;

    // Saturating instruction-count increment and sequential PC increment.
    always_comb begin
        w_cnt_next  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
        w_pc_inc    = r_pc + PC_W'(1);
        w_pc_at_max = (r_pc == '1);
    end

    // Sequencer: state, PC, counter and all flags registered together.
    always_ff @(posedge clk) begin
        if (init) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_pc      <= start_addr;
                        r_cnt     <= '0;
                        r_wrap    <= 1'b0;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stall) begin
                        r_pc  <= r_pc;
                    end else if (halt) begin
                        r_cnt     <= w_cnt_next;
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (branch_taken) begin
                        r_pc  <= branch_target;
                        r_cnt <= w_cnt_next;
                    end else begin
                        r_pc  <= w_pc_inc;
                        r_cnt <= w_cnt_next;
                        if (w_pc_at_max) begin
                            r_wrap <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign running   = r_running;
    assign done      = r_done;
    assign instr_cnt = r_cnt;
    assign wrap_err  = r_wrap;

endmodule
